// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment scanner: one-hot digit sweep with programmable dwell, per-digit blanking and frame pulse.
// Optional ghosting dead time at the start of each slot is enabled by defining SCAN_GHOST_GUARD_EN.
module display_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int SEG_W      = 7,
    parameter int DWELL      = 50000,
    parameter int GUARD      = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        EN,
    input  logic [NUM_DIGITS*SEG_W-1:0] SEG_IN,
    input  logic [NUM_DIGITS-1:0]       BLANK,
    output logic [NUM_DIGITS-1:0]       DIG_SEL,
    output logic [SEG_W-1:0]            SEG_OUT,
    output logic                        FRAME_TICK
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);

`ifdef SCAN_GHOST_GUARD_EN
    localparam bit GUARD_ON = 1'b1;
`else
    localparam bit GUARD_ON = 1'b0;
`endif

    logic [IDX_W-1:0]      idx;
    logic [CNT_W-1:0]      cnt;

    logic [NUM_DIGITS-1:0] dig_onehot;
    logic [SEG_W-1:0]      seg_pick;
    logic                  blank_pick;
    logic                  slot_last;
    logic                  frame_last;
    logic                  in_guard;

    // Decode the current digit: select line, segment slice and blank bit.
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        dig_onehot = '0;
        seg_pick   = '0;
        blank_pick = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                dig_onehot[i] = 1'b1;
                seg_pick      = SEG_IN[i*SEG_W +: SEG_W];
                blank_pick    = BLANK[i];
            end
        end
    end

    assign slot_last  = (cnt == CNT_LAST);
    assign frame_last = slot_last && (idx == IDX_LAST);
    // Dead time keeps the digit driver off while segment lines settle; slot timing is unaffected.
    assign in_guard   = GUARD_ON && (cnt < GUARD_CNT);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx        <= '0;
            cnt        <= '0;
            DIG_SEL    <= '0;
            SEG_OUT    <= '0;
            FRAME_TICK <= 1'b0;
        end else if (!EN) begin
            // Paused: position is held so the scan resumes mid-slot.
            DIG_SEL    <= '0;
            SEG_OUT    <= '0;
            FRAME_TICK <= 1'b0;
        end else begin
            DIG_SEL    <= (blank_pick || in_guard) ? '0 : dig_onehot;
            SEG_OUT    <= blank_pick ? '0 : seg_pick;
            FRAME_TICK <= frame_last;
            if (slot_last) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux (4 digits, 7 segments, dwell 3, guard 1).
// Table-driven frame/blank/mid-slot vectors followed by hand-written pause and reset sequences.
module tb_display_scan_mux;

    localparam int ND = 4;
    localparam int SW = 7;

    typedef struct {
        logic           rst;
        logic           en;
        logic [ND-1:0]  blank;
        logic [ND*SW-1:0] seg_in;
        logic [ND-1:0]  exp_dig;
        logic [SW-1:0]  exp_seg;
        logic           exp_ft;
        logic           slot_start;
    } vec_t;

    localparam logic [ND*SW-1:0] SEGS   = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    localparam logic [ND*SW-1:0] SEGS66 = {7'h4F, 7'h5B, 7'h66, 7'h3F};

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             EN = 1'b0;
    logic [ND*SW-1:0] SEG_IN = SEGS;
    logic [ND-1:0]    BLANK = '0;
    logic [ND-1:0]    DIG_SEL;
    logic [SW-1:0]    SEG_OUT;
    logic             FRAME_TICK;

    int n_vec = 0;
    int n_err = 0;

    vec_t tbl[$];

    display_scan_mux #(.NUM_DIGITS(ND), .SEG_W(SW), .DWELL(3), .GUARD(1)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .SEG_IN(SEG_IN), .BLANK(BLANK),
        .DIG_SEL(DIG_SEL), .SEG_OUT(SEG_OUT), .FRAME_TICK(FRAME_TICK)
    );

    always #5 CLK = ~CLK;

    // With the ghost guard built in, the first cycle of each slot has the digit driver off.
    function automatic logic [ND-1:0] guarded(input logic [ND-1:0] d, input logic ss);
`ifdef SCAN_GHOST_GUARD_EN
        return ss ? '0 : d;
`else
        return d;
`endif
    endfunction

    function automatic vec_t mk(input logic rst, input logic en, input logic [ND-1:0] blank,
                                input logic [ND*SW-1:0] seg, input logic [ND-1:0] dig,
                                input logic [SW-1:0] so, input logic ft, input logic ss);
        vec_t v;
        v.rst = rst; v.en = en; v.blank = blank; v.seg_in = seg;
        v.exp_dig = dig; v.exp_seg = so; v.exp_ft = ft; v.slot_start = ss;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one vector, clock it, then compare the registered outputs just after the edge.
    task automatic apply(input vec_t v, input string tag);
        RST = v.rst; EN = v.en; BLANK = v.blank; SEG_IN = v.seg_in;
        @(posedge CLK);
        #1;
        n_vec++;
        check({tag, ".dig_sel"}, 32'(DIG_SEL), 32'(guarded(v.exp_dig, v.slot_start)));
        check({tag, ".seg_out"}, 32'(SEG_OUT), 32'(v.exp_seg));
        check({tag, ".frame_tick"}, 32'(FRAME_TICK), 32'(v.exp_ft));
    endtask

    initial begin
        // Reset, then two full frames (second with digit 2 blanked), then a mid-slot segment change.
        tbl.push_back(mk(1, 0, 4'b0000, SEGS,   4'b0000, 7'h00, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, SEGS,   4'b0001, 7'h3F, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0000, SEGS,   4'b0001, 7'h3F, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, SEGS,   4'b0001, 7'h3F, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, SEGS,   4'b0010, 7'h06, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0000, SEGS,   4'b0010, 7'h06, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, SEGS,   4'b0010, 7'h06, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, SEGS,   4'b0100, 7'h5B, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0000, SEGS,   4'b0100, 7'h5B, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, SEGS,   4'b0100, 7'h5B, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, SEGS,   4'b1000, 7'h4F, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0000, SEGS,   4'b1000, 7'h4F, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, SEGS,   4'b1000, 7'h4F, 1, 0));
        tbl.push_back(mk(0, 1, 4'b0000, SEGS,   4'b0001, 7'h3F, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0100, SEGS,   4'b0001, 7'h3F, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0100, SEGS,   4'b0001, 7'h3F, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0100, SEGS,   4'b0010, 7'h06, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0100, SEGS,   4'b0010, 7'h06, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0100, SEGS,   4'b0010, 7'h06, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0100, SEGS,   4'b0000, 7'h00, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0100, SEGS,   4'b0000, 7'h00, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0100, SEGS,   4'b0000, 7'h00, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0100, SEGS,   4'b1000, 7'h4F, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0100, SEGS,   4'b1000, 7'h4F, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0100, SEGS,   4'b1000, 7'h4F, 1, 0));
        tbl.push_back(mk(0, 1, 4'b0000, SEGS,   4'b0001, 7'h3F, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0000, SEGS,   4'b0001, 7'h3F, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, SEGS,   4'b0001, 7'h3F, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, SEGS,   4'b0010, 7'h06, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0000, SEGS66, 4'b0010, 7'h66, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0000, SEGS66, 4'b0010, 7'h66, 0, 0));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("tbl%0d", i));

        // Pause after the second cycle of digit 1: outputs dark, then one more digit-1 cycle.
        apply(mk(1, 0, 4'b0000, SEGS, 4'b0000, 7'h00, 0, 0), "p_rst");
        apply(mk(0, 1, 4'b0000, SEGS, 4'b0001, 7'h3F, 0, 1), "p_d0a");
        apply(mk(0, 1, 4'b0000, SEGS, 4'b0001, 7'h3F, 0, 0), "p_d0b");
        apply(mk(0, 1, 4'b0000, SEGS, 4'b0001, 7'h3F, 0, 0), "p_d0c");
        apply(mk(0, 1, 4'b0000, SEGS, 4'b0010, 7'h06, 0, 1), "p_d1a");
        apply(mk(0, 1, 4'b0000, SEGS, 4'b0010, 7'h06, 0, 0), "p_d1b");
        for (int k = 0; k < 5; k++)
            apply(mk(0, 0, 4'b0000, SEGS, 4'b0000, 7'h00, 0, 0), $sformatf("p_hold%0d", k));
        apply(mk(0, 1, 4'b0000, SEGS, 4'b0010, 7'h06, 0, 0), "p_d1c");
        apply(mk(0, 1, 4'b0000, SEGS, 4'b0100, 7'h5B, 0, 1), "p_d2a");
        apply(mk(0, 1, 4'b0000, SEGS, 4'b0100, 7'h5B, 0, 0), "p_d2b");
        apply(mk(0, 1, 4'b0000, SEGS, 4'b0100, 7'h5B, 0, 0), "p_d2c");
        apply(mk(0, 1, 4'b0000, SEGS, 4'b1000, 7'h4F, 0, 1), "p_d3a");
        apply(mk(0, 1, 4'b0000, SEGS, 4'b1000, 7'h4F, 0, 0), "p_d3b");

        // Reset with EN high on the frame-tick position: reset wins, then a clean restart at digit 0.
        apply(mk(1, 1, 4'b0000, SEGS, 4'b0000, 7'h00, 0, 0), "r_hit");
        apply(mk(0, 1, 4'b0000, SEGS, 4'b0001, 7'h3F, 0, 1), "r_d0a");
        apply(mk(0, 1, 4'b0000, SEGS, 4'b0001, 7'h3F, 0, 0), "r_d0b");
        apply(mk(0, 1, 4'b0000, SEGS, 4'b0001, 7'h3F, 0, 0), "r_d0c");
        apply(mk(0, 1, 4'b0000, SEGS, 4'b0010, 7'h06, 0, 1), "r_d1a");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
